// File: rtl/gh_pkg.sv
// Shared constants and types for the Groestl ShiftBytes datapath: row count,
// byte/state types and the per-row left-rotation amounts for P and Q.
package gh_pkg;

    localparam int GH_ROWS = 8;

    typedef logic [7:0]              gh_byte_t;
    typedef logic [8*GH_ROWS*8-1:0]  gh_state512_t;
    typedef logic [8*GH_ROWS*16-1:0] gh_state1024_t;

    typedef logic [3:0]                gh_shift_t;
    typedef gh_shift_t [GH_ROWS-1:0]   gh_shift_vec_t;

    // Element [0] is the least significant nibble, so row 0 is written last.
    localparam gh_shift_vec_t GH_SHIFT_P512  = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    localparam gh_shift_vec_t GH_SHIFT_Q512  = {4'd6, 4'd4, 4'd2, 4'd0, 4'd7, 4'd5, 4'd3, 4'd1};
    localparam gh_shift_vec_t GH_SHIFT_P1024 = {4'd11, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    localparam gh_shift_vec_t GH_SHIFT_Q1024 = {4'd6, 4'd4, 4'd2, 4'd0, 4'd11, 4'd5, 4'd3, 4'd1};

endpackage

// File: rtl/gh_shift_bytes_logic.sv
// Combinational ShiftBytes: rotates each row left by its P/Q amount.
// With GH_SHIFT_TRANSPOSE_EN the result can optionally be transposed (8x8 only).
module gh_shift_bytes_logic
    import gh_pkg::*;
#(
    parameter int COLS = 8
) (
    input  logic [8*GH_ROWS*COLS-1:0] state_i,
    input  logic                      mode_q,
`ifdef GH_SHIFT_TRANSPOSE_EN
    input  logic                      transpose_i,
`endif
    output logic [8*GH_ROWS*COLS-1:0] state_o
);

    localparam int IDX_W = (COLS > 8) ? 4 : 3;
    localparam gh_shift_vec_t SH_P = (COLS == 16) ? GH_SHIFT_P1024 : GH_SHIFT_P512;
    localparam gh_shift_vec_t SH_Q = (COLS == 16) ? GH_SHIFT_Q1024 : GH_SHIFT_Q512;

    typedef logic [IDX_W-1:0] col_idx_t;

    gh_byte_t in_b  [GH_ROWS][COLS];
    gh_byte_t shf_b [GH_ROWS][COLS];

    // COLS is a power of two, so the column index wraps by plain truncation.
    for (genvar r = 0; r < GH_ROWS; r++) begin : g_row
        gh_shift_t sh_r;
        assign sh_r = mode_q ? SH_Q[r] : SH_P[r];
        for (genvar c = 0; c < COLS; c++) begin : g_col
            col_idx_t src;
            assign in_b[r][c]  = state_i[8*(c*GH_ROWS+r) +: 8];
            assign src         = col_idx_t'(c) + col_idx_t'(sh_r);
            assign shf_b[r][c] = in_b[r][src];
        end
    end

`ifdef GH_SHIFT_TRANSPOSE_EN
    if (COLS != GH_ROWS) begin : g_bad_transpose
        $error("gh_shift_bytes_logic: transpose requires a square 8x8 state");
    end else begin : g_out
        for (genvar r = 0; r < GH_ROWS; r++) begin : g_row
            for (genvar c = 0; c < COLS; c++) begin : g_col
                assign state_o[8*(c*GH_ROWS+r) +: 8] = transpose_i ? shf_b[c][r] : shf_b[r][c];
            end
        end
    end
`else
    for (genvar r = 0; r < GH_ROWS; r++) begin : g_out_row
        for (genvar c = 0; c < COLS; c++) begin : g_out_col
            assign state_o[8*(c*GH_ROWS+r) +: 8] = shf_b[r][c];
        end
    end
`endif

endmodule

// File: rtl/gh_shift_bytes_pipe.sv
// Two-entry elastic ShiftBytes stage (input register A, output register B)
// with valid/ready handshake and flush. Optional feature: GH_SHIFT_TRANSPOSE_EN.
module gh_shift_bytes_pipe
    import gh_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*ROWS*COLS-1:0] in_data,
    input  logic                   in_mode_q,
    input  logic [TAG_W-1:0]       in_tag,
`ifdef GH_SHIFT_TRANSPOSE_EN
    input  logic                   in_transpose,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*ROWS*COLS-1:0] out_data,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int DATA_W = 8 * ROWS * COLS;

    if (ROWS != GH_ROWS) begin : g_bad_rows
        $error("gh_shift_bytes_pipe: ROWS must be 8");
    end
    if (COLS != 8 && COLS != 16) begin : g_bad_cols
        $error("gh_shift_bytes_pipe: COLS must be 8 or 16");
    end

    logic              valid_a_q, valid_a_d;
    logic [DATA_W-1:0] data_a_q,  data_a_d;
    logic              mode_a_q,  mode_a_d;
    logic [TAG_W-1:0]  tag_a_q,   tag_a_d;
`ifdef GH_SHIFT_TRANSPOSE_EN
    logic              xpose_a_q, xpose_a_d;
`endif
    logic              valid_b_q, valid_b_d;
    logic [DATA_W-1:0] data_b_q,  data_b_d;
    logic [TAG_W-1:0]  tag_b_q,   tag_b_d;

    logic              b_free;
    logic              a_to_b;
    logic              accept;
    logic [DATA_W-1:0] shifted;

    gh_shift_bytes_logic #(
        .COLS        (COLS)
    ) u_logic (
        .state_i     (data_a_q),
        .mode_q      (mode_a_q),
`ifdef GH_SHIFT_TRANSPOSE_EN
        .transpose_i (xpose_a_q),
`endif
        .state_o     (shifted)
    );

    // B frees up when empty or being drained; A may refill whenever it empties into B.
    assign b_free   = !valid_b_q || out_ready;
    assign in_ready = (!valid_a_q || b_free) && !flush;
    assign a_to_b   = valid_a_q && b_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path leaves it unassigned (no latch).
        valid_a_d = valid_a_q;
        data_a_d  = data_a_q;
        mode_a_d  = mode_a_q;
        tag_a_d   = tag_a_q;
`ifdef GH_SHIFT_TRANSPOSE_EN
        xpose_a_d = xpose_a_q;
`endif
        valid_b_d = valid_b_q;
        data_b_d  = data_b_q;
        tag_b_d   = tag_b_q;

        if (flush) begin
            valid_a_d = 1'b0;
            valid_b_d = 1'b0;
        end else begin
            if (a_to_b) begin
                valid_b_d = 1'b1;
                data_b_d  = shifted;
                tag_b_d   = tag_a_q;
            end else if (out_ready) begin
                valid_b_d = 1'b0;
            end

            if (accept) begin
                valid_a_d = 1'b1;
                data_a_d  = in_data;
                mode_a_d  = in_mode_q;
                tag_a_d   = in_tag;
`ifdef GH_SHIFT_TRANSPOSE_EN
                xpose_a_d = in_transpose;
`endif
            end else if (a_to_b) begin
                valid_a_d = 1'b0;
            end
        end
    end

    // NOTE: the data registers are reset too, because out_data/out_tag must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            valid_a_q <= 1'b0;
            data_a_q  <= '0;
            mode_a_q  <= 1'b0;
            tag_a_q   <= '0;
`ifdef GH_SHIFT_TRANSPOSE_EN
            xpose_a_q <= 1'b0;
`endif
            valid_b_q <= 1'b0;
            data_b_q  <= '0;
            tag_b_q   <= '0;
        end else begin
            valid_a_q <= valid_a_d;
            data_a_q  <= data_a_d;
            mode_a_q  <= mode_a_d;
            tag_a_q   <= tag_a_d;
`ifdef GH_SHIFT_TRANSPOSE_EN
            xpose_a_q <= xpose_a_d;
`endif
            valid_b_q <= valid_b_d;
            data_b_q  <= data_b_d;
            tag_b_q   <= tag_b_d;
        end
    end

    assign out_valid = valid_b_q;
    assign out_data  = data_b_q;
    assign out_tag   = tag_b_q;

endmodule

// File: tb/tb_gh_shift_bytes_pipe.sv
// Directed bench for gh_shift_bytes_pipe: an 8-column and (without the transpose
// option) a 16-column instance; outputs are sampled on the falling clock edge.
module tb_gh_shift_bytes_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic         flush8, in_valid8, in_ready8, in_mode_q8, out_valid8, out_ready8;
    logic [511:0] in_data8, out_data8;
    logic [3:0]   in_tag8, out_tag8;
`ifdef GH_SHIFT_TRANSPOSE_EN
    logic         in_transpose8;
`endif

    gh_shift_bytes_pipe #(.ROWS(8), .COLS(8), .TAG_W(4)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush8),
        .in_valid     (in_valid8),
        .in_ready     (in_ready8),
        .in_data      (in_data8),
        .in_mode_q    (in_mode_q8),
        .in_tag       (in_tag8),
`ifdef GH_SHIFT_TRANSPOSE_EN
        .in_transpose (in_transpose8),
`endif
        .out_valid    (out_valid8),
        .out_ready    (out_ready8),
        .out_data     (out_data8),
        .out_tag      (out_tag8)
    );

`ifndef GH_SHIFT_TRANSPOSE_EN
    logic          flush16, in_valid16, in_ready16, in_mode_q16, out_valid16, out_ready16;
    logic [1023:0] in_data16, out_data16;
    logic [3:0]    in_tag16, out_tag16;

    gh_shift_bytes_pipe #(.ROWS(8), .COLS(16), .TAG_W(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush16),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_data   (in_data16),
        .in_mode_q (in_mode_q16),
        .in_tag    (in_tag16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_data  (out_data16),
        .out_tag   (out_tag16)
    );
`endif

    logic [511:0]  ramp8;
    logic [1023:0] ramp16;

    // byte (r,c) = c*8 + r
    function automatic logic [1023:0] ramp(input int cols);
        logic [1023:0] d = '0;
        for (int c = 0; c < cols; c++)
            for (int r = 0; r < 8; r++)
                d |= 1024'(c * 8 + r) << (8 * (c * 8 + r));
        return d;
    endfunction

    function automatic logic [7:0] byte_at(input logic [1023:0] d, input int r, input int c);
        return 8'(d >> (8 * (c * 8 + r)));
    endfunction

    task automatic send_one8(input logic [511:0] d, input logic q, input logic [3:0] t,
                             output logic early_v, output logic late_v,
                             output logic [511:0] od, output logic [3:0] ot);
        @(negedge clk);
        in_valid8 = 1'b1; in_data8 = d; in_mode_q8 = q; in_tag8 = t; out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        early_v = out_valid8;
        @(negedge clk);
        late_v = out_valid8; od = out_data8; ot = out_tag8;
    endtask

    task automatic drain8;
        in_valid8 = 1'b0; out_ready8 = 1'b1; flush8 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid8 !== 1'b0 || out_data8 !== '0 || out_tag8 !== 4'h0) begin
            n_fail++;
            $display("FAIL reset8: valid=%b tag=%h data_nonzero=%b, required 0/0/0", out_valid8, out_tag8, |out_data8);
        end
`ifndef GH_SHIFT_TRANSPOSE_EN
        n_tests++;
        if (out_valid16 !== 1'b0 || out_data16 !== '0 || out_tag16 !== 4'h0) begin
            n_fail++;
            $display("FAIL reset16: valid=%b tag=%h data_nonzero=%b, required 0/0/0", out_valid16, out_tag16, |out_data16);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready8);
        end
    endtask

    task automatic test_p512;
        logic ev, lv; logic [511:0] od; logic [3:0] ot; logic [1023:0] w;
        int tbl [4][3] = '{'{0, 0, 'h00}, '{1, 0, 'h09}, '{7, 0, 'h3F}, '{2, 6, 'h02}};
        send_one8(ramp8, 1'b0, 4'h5, ev, lv, od, ot);
        w = {512'd0, od};
        n_tests++;
        if (ev !== 1'b0) begin n_fail++; $display("FAIL p512_early: out_valid=%b one cycle after accept, required 0", ev); end
        n_tests++;
        if (lv !== 1'b1) begin n_fail++; $display("FAIL p512_valid: out_valid=%b, required 1", lv); end
        n_tests++;
        if (ot !== 4'h5) begin n_fail++; $display("FAIL p512_tag: got %h, required 5", ot); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (byte_at(w, tbl[i][0], tbl[i][1]) !== 8'(tbl[i][2])) begin
                n_fail++;
                $display("FAIL p512_byte(%0d,%0d): got %h, required %h", tbl[i][0], tbl[i][1],
                         byte_at(w, tbl[i][0], tbl[i][1]), 8'(tbl[i][2]));
            end
        end
    endtask

    task automatic test_q512;
        logic ev, lv; logic [511:0] od; logic [3:0] ot; logic [1023:0] w;
        int tbl [3][3] = '{'{0, 0, 'h08}, '{3, 7, 'h33}, '{4, 3, 'h1C}};
        send_one8(ramp8, 1'b1, 4'hC, ev, lv, od, ot);
        w = {512'd0, od};
        n_tests++;
        if (lv !== 1'b1 || ot !== 4'hC) begin
            n_fail++; $display("FAIL q512_beat: valid=%b tag=%h, required 1/c", lv, ot);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (byte_at(w, tbl[i][0], tbl[i][1]) !== 8'(tbl[i][2])) begin
                n_fail++;
                $display("FAIL q512_byte(%0d,%0d): got %h, required %h", tbl[i][0], tbl[i][1],
                         byte_at(w, tbl[i][0], tbl[i][1]), 8'(tbl[i][2]));
            end
        end
    endtask

`ifndef GH_SHIFT_TRANSPOSE_EN
    task automatic test_cols16;
        // mode, row, col, expected
        int tbl [5][4] = '{'{0, 7, 0, 'h5F}, '{0, 7, 5, 'h07}, '{1, 3, 9, 'h23},
                           '{1, 0, 15, 'h00}, '{1, 7, 3, 'h4F}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid16 = 1'b1; in_data16 = ramp16; in_mode_q16 = tbl[i][0] != 0;
            in_tag16 = 4'(i + 1); out_ready16 = 1'b1;
            @(negedge clk);
            in_valid16 = 1'b0;
            @(negedge clk);
            n_tests++;
            if (out_valid16 !== 1'b1 || out_tag16 !== 4'(i + 1) ||
                byte_at(out_data16, tbl[i][1], tbl[i][2]) !== 8'(tbl[i][3])) begin
                n_fail++;
                $display("FAIL cols16_byte(%0d,%0d) mode %0d: valid=%b tag=%h byte=%h, required 1/%h/%h",
                         tbl[i][1], tbl[i][2], tbl[i][0], out_valid16, out_tag16,
                         byte_at(out_data16, tbl[i][1], tbl[i][2]), 4'(i + 1), 8'(tbl[i][3]));
            end
        end
    endtask
`endif

    task automatic test_throughput;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            out_ready8 = 1'b1;
            in_valid8  = (k < 6);
            in_tag8    = 4'(k);
            in_data8   = {64{8'(8'h30 + k)}};
            #1;
            if (k < 6) begin
                n_tests++;
                if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL tput_in_ready k=%0d: got %b, required 1", k, in_ready8); end
            end
            if (k >= 2) begin
                n_tests++;
                if (out_valid8 !== 1'b1 || out_tag8 !== 4'(k - 2)) begin
                    n_fail++;
                    $display("FAIL tput_out k=%0d: valid=%b tag=%h, required 1/%h", k, out_valid8, out_tag8, 4'(k - 2));
                end
            end
        end
        drain8();
    endtask

    task automatic test_stall;
        int acc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            out_ready8 = 1'b0;
            in_valid8  = 1'b1;
            in_tag8    = 4'(8 + acc);
            in_data8   = {64{8'(8'h50 + acc)}};
            #1;
            if (in_ready8) acc++;
        end
        n_tests++;
        if (acc !== 2) begin n_fail++; $display("FAIL stall_absorb: accepted %0d beats with out_ready low, required 2", acc); end
        n_tests++;
        if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1) begin
            n_fail++; $display("FAIL stall_full: in_ready=%b out_valid=%b, required 0/1", in_ready8, out_valid8);
        end
        @(negedge clk);
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        #1;
        n_tests++;
        if (out_tag8 !== 4'h8 || out_data8 !== {64{8'h50}}) begin
            n_fail++; $display("FAIL stall_first: tag=%h, required 8", out_tag8);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid8 !== 1'b1 || out_tag8 !== 4'h9 || out_data8 !== {64{8'h51}}) begin
            n_fail++; $display("FAIL stall_second: valid=%b tag=%h, required 1/9", out_valid8, out_tag8);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL stall_empty: out_valid=%b, required 0", out_valid8); end
        drain8();
    endtask

    task automatic test_back_to_back;
        int exp_q [$];
        int sent = 0, recv = 0, low_acc = 0, cyc = 0, idx;
        logic prev_stall = 1'b0;
        logic [511:0] prev_data = '0;
        logic [3:0] prev_tag = '0;
        logic acc, hs;
        while (recv < 16 && cyc < 300) begin
            @(negedge clk);
            out_ready8 = (cyc % 3 == 0);
            in_valid8  = (sent < 16);
            in_tag8    = 4'(sent);
            in_mode_q8 = sent[0];
            in_data8   = {64{8'(8'hA0 + sent)}};
            #1;
            if (prev_stall) begin
                n_tests++;
                if (out_valid8 !== 1'b1 || out_data8 !== prev_data || out_tag8 !== prev_tag) begin
                    n_fail++;
                    $display("FAIL b2b_stall_hold: valid=%b tag=%h, required 1/%h held", out_valid8, out_tag8, prev_tag);
                end
            end
            acc = in_valid8 && in_ready8;
            hs  = out_valid8 && out_ready8;
            if (hs) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_order: extra beat tag %h, required none", out_tag8);
                end else begin
                    idx = exp_q.pop_front();
                    if (out_tag8 !== 4'(idx) || out_data8 !== {64{8'(8'hA0 + idx)}}) begin
                        n_fail++;
                        $display("FAIL b2b_order: tag %h byte %h, required %h / %h", out_tag8, out_data8[7:0], 4'(idx), 8'(8'hA0 + idx));
                    end
                end
                recv++;
            end
            if (acc) begin exp_q.push_back(sent); sent++; end
            if (!out_ready8) begin
                if (acc) low_acc++;
                n_tests++;
                if (low_acc > 2) begin n_fail++; $display("FAIL b2b_low_absorb: %0d beats taken while out_ready low, required <=2", low_acc); end
            end else begin
                low_acc = 0;
            end
            prev_stall = out_valid8 && !out_ready8;
            prev_data  = out_data8;
            prev_tag   = out_tag8;
            cyc++;
        end
        n_tests++;
        if (recv != 16 || sent != 16) begin
            n_fail++; $display("FAIL b2b_count: sent %0d received %0d, required 16/16", sent, recv);
        end
        drain8();
    endtask

    task automatic test_flush;
        logic saw = 1'b0;
        logic ev, lv; logic [511:0] od; logic [3:0] ot;
        @(negedge clk);
        out_ready8 = 1'b0; in_valid8 = 1'b1; in_tag8 = 4'h1; in_data8 = {64{8'h11}};
        @(negedge clk);
        in_tag8 = 4'h2; in_data8 = {64{8'h22}};
        @(negedge clk);
        in_tag8 = 4'h3; in_data8 = {64{8'h33}}; flush8 = 1'b1; out_ready8 = 1'b1;
        #1;
        n_tests++;
        if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1) begin
            n_fail++; $display("FAIL flush_cycle: in_ready=%b out_valid=%b, required 0/1", in_ready8, out_valid8);
        end
        @(negedge clk);
        flush8 = 1'b0; in_valid8 = 1'b0;
        n_tests++;
        if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL flush_next: out_valid=%b, required 0", out_valid8); end
        repeat (3) begin
            @(negedge clk);
            saw |= out_valid8;
        end
        n_tests++;
        if (saw !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: out_valid=%b after flush, required 0", saw); end
        send_one8({64{8'h44}}, 1'b0, 4'h4, ev, lv, od, ot);
        n_tests++;
        if (lv !== 1'b1 || ot !== 4'h4 || od !== {64{8'h44}}) begin
            n_fail++; $display("FAIL flush_resume: valid=%b tag=%h, required 1/4", lv, ot);
        end
        drain8();
    endtask

`ifdef GH_SHIFT_TRANSPOSE_EN
    task automatic test_transpose;
        logic ev, lv; logic [511:0] od; logic [3:0] ot; logic [1023:0] w;
        in_transpose8 = 1'b1;
        send_one8(ramp8, 1'b0, 4'hA, ev, lv, od, ot);
        w = {512'd0, od};
        n_tests++;
        if (lv !== 1'b1 || byte_at(w, 0, 1) !== 8'h09 || byte_at(w, 1, 0) !== 8'h08) begin
            n_fail++;
            $display("FAIL xpose_on: valid=%b (0,1)=%h (1,0)=%h, required 1/09/08", lv, byte_at(w, 0, 1), byte_at(w, 1, 0));
        end
        in_transpose8 = 1'b0;
        send_one8(ramp8, 1'b0, 4'hB, ev, lv, od, ot);
        w = {512'd0, od};
        n_tests++;
        if (lv !== 1'b1 || byte_at(w, 0, 1) !== 8'h08 || byte_at(w, 1, 0) !== 8'h09) begin
            n_fail++;
            $display("FAIL xpose_off: valid=%b (0,1)=%h (1,0)=%h, required 1/08/09", lv, byte_at(w, 0, 1), byte_at(w, 1, 0));
        end
        drain8();
    endtask
`endif

    task automatic test_reset_mid;
        @(negedge clk);
        out_ready8 = 1'b0; in_valid8 = 1'b1; in_data8 = ramp8; in_mode_q8 = 1'b0; in_tag8 = 4'h6;
        @(negedge clk);
        in_tag8 = 4'h7;
        @(negedge clk);
        n_tests++;
        if (out_valid8 !== 1'b1 || out_tag8 !== 4'h6) begin
            n_fail++; $display("FAIL rstmid_pre: valid=%b tag=%h, required 1/6", out_valid8, out_tag8);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid8 !== 1'b0 || out_data8 !== '0 || out_tag8 !== 4'h0) begin
            n_fail++;
            $display("FAIL rstmid_clear: valid=%b tag=%h data_nonzero=%b, required 0/0/0", out_valid8, out_tag8, |out_data8);
        end
        @(negedge clk);
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_release: in_ready=%b out_valid=%b, required 1/0", in_ready8, out_valid8);
        end
    endtask

    initial begin
        logic [1023:0] tmp;
        flush8 = 1'b0; in_valid8 = 1'b0; in_mode_q8 = 1'b0; in_tag8 = '0;
        in_data8 = '0; out_ready8 = 1'b1;
`ifdef GH_SHIFT_TRANSPOSE_EN
        in_transpose8 = 1'b0;
`else
        flush16 = 1'b0; in_valid16 = 1'b0; in_mode_q16 = 1'b0; in_tag16 = '0;
        in_data16 = '0; out_ready16 = 1'b1;
`endif
        tmp    = ramp(8);
        ramp8  = tmp[511:0];
        ramp16 = ramp(16);

        test_reset();
        test_p512();
        test_q512();
`ifndef GH_SHIFT_TRANSPOSE_EN
        test_cols16();
`endif
        test_throughput();
        test_stall();
        test_back_to_back();
        test_flush();
`ifdef GH_SHIFT_TRANSPOSE_EN
        test_transpose();
`endif
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
